// File: rtl/route_rom_mp.sv
// Multi-port read-only lookup table: NUM_PORTS independent channels, out-of-range index flagged.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) from request accept to rsp_valid.
// Backpressure: valid/ready per port; a full pipeline stalls req_ready until the response drains.
//
// Ports:
//   clk, rst_n            sole clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   per-port request handshake
//   req_idx               per-port index, port p at [p*ADDR_BITS +: ADDR_BITS]
//   rsp_valid/rsp_ready   per-port response handshake
//   rsp_data              per-port entry, port p at [p*WIDTH +: WIDTH]; 0 when out of range
//   rsp_err               per-port out-of-range flag, qualified by rsp_valid
module route_rom_mp #(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 9,
  parameter int DEPTH     = 1 << ADDR_BITS,
  parameter int NUM_PORTS = 1,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*ADDR_BITS-1:0] req_idx,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           rsp_valid,
  output logic [NUM_PORTS*WIDTH-1:0]     rsp_data,
  output logic [NUM_PORTS-1:0]           rsp_err,
  input  logic [NUM_PORTS-1:0]           rsp_ready
);

  // One extra bit so DEPTH == 2^ADDR_BITS is representable in the range compare.
  localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

  // Table contents are fixed at elaboration; reset never touches them.
  logic [WIDTH-1:0] mem [DEPTH];

  // Default image: entry i holds i mod 2^WIDTH (the cast truncates).
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign mem[i] = WIDTH'(i);
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_BITS-1:0] idx;
    logic                 lk_err;
    logic [WIDTH-1:0]     lk_dat;
    logic                 s1_vld;
    logic                 s1_err;
    logic [WIDTH-1:0]     s1_dat;
    logic                 s1_rdy;
    logic                 nxt_rdy;   // whether whatever follows stage 1 can take its content

    assign idx    = req_idx[p*ADDR_BITS +: ADDR_BITS];
    assign lk_err = ({1'b0, idx} >= DEPTH_W);
    // Out-of-range indices never reach the array read result.
    assign lk_dat = lk_err ? '0 : mem[idx];

    // Stage 1 may load when empty or when its content leaves this same cycle.
    assign s1_rdy       = !s1_vld || nxt_rdy;
    assign req_ready[p] = s1_rdy;

    // Payload only loads on an accepted request, so it holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld <= 1'b0;
        s1_err <= 1'b0;
        s1_dat <= '0;
      end else if (s1_rdy) begin
        s1_vld <= req_valid[p];
        if (req_valid[p]) begin
          s1_err <= lk_err;
          s1_dat <= lk_dat;
        end
      end
    end

    if (OUT_REG == 0) begin : g_direct
      assign nxt_rdy                  = rsp_ready[p];
      assign rsp_valid[p]             = s1_vld;
      assign rsp_err[p]               = s1_err;
      assign rsp_data[p*WIDTH +: WIDTH] = s1_dat;
    end else begin : g_outreg
      logic             s2_vld;
      logic             s2_err;
      logic [WIDTH-1:0] s2_dat;

      assign nxt_rdy = !s2_vld || rsp_ready[p];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_vld <= 1'b0;
          s2_err <= 1'b0;
          s2_dat <= '0;
        end else if (nxt_rdy) begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_err <= s1_err;
            s2_dat <= s1_dat;
          end
        end
      end

      assign rsp_valid[p]               = s2_vld;
      assign rsp_err[p]                 = s2_err;
      assign rsp_data[p*WIDTH +: WIDTH] = s2_dat;
    end
  end

endmodule
